// File: rtl/riscv_exec_stage_if.sv
// rtl/riscv_exec_stage_if.sv - stream bundle between decode, execute stage and MEM/WB
// Purpose: groups the upstream instruction stream and downstream result stream.
// Ports (signals):
//   in_valid/in_ready      upstream handshake
//   in_is_imm, in_funct3, in_funct7_5, in_rs1, in_rs2, in_imm, in_tag  decoded instruction
//   out_valid/out_ready    downstream handshake
//   out_result, out_tag, out_wen, out_illegal                         registered result
// Modports: slave = execute stage, master = environment driving/consuming it.
interface riscv_exec_stage_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_is_imm;
  logic [2:0]       in_funct3;
  logic             in_funct7_5;
  logic [31:0]      in_rs1;
  logic [31:0]      in_rs2;
  logic [31:0]      in_imm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_wen;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_is_imm, in_funct3, in_funct7_5, in_rs1, in_rs2, in_imm, in_tag,
    output in_ready,
    output out_valid, out_result, out_tag, out_wen, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_is_imm, in_funct3, in_funct7_5, in_rs1, in_rs2, in_imm, in_tag,
    input  in_ready,
    input  out_valid, out_result, out_tag, out_wen, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/riscv_exec_stage.sv
// rtl/riscv_exec_stage.sv - RV32I OP/OP-IMM execute stage with registered skid output
// Purpose: decodes funct3/funct7 into an ALU opcode, computes the result (SLT/SLTU done
//   locally), and registers it toward MEM/WB behind a valid/ready handshake with a
//   main register plus one skid entry.
// Ports:
//   clk    in  clock, all state on rising edge
//   rst_n  in  asynchronous active-low reset
//   flush  in  synchronous flush, highest priority
//   io     riscv_exec_stage_if.slave stream bundle (instruction in, result out)
module riscv_exec_stage #(
  parameter int TAG_W   = 5,
  parameter bit SKID_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  riscv_exec_stage_if.slave     io
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SRL  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;

  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic             wen;
    logic             illegal;
  } entry_t;

  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [3:0]  alu_op;
  logic        use_cmp;
  logic        illegal;
  logic [31:0] alu_res;
  logic        lt;
  entry_t      new_entry;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_full_q, skid_full_d;
  logic   load_main;
  logic   accept;

  // Decode and execute
  always_comb begin
    op_b    = io.in_is_imm ? io.in_imm : io.in_rs2;
    shamt   = op_b[4:0];
    alu_op  = ALU_ADD;
    use_cmp = 1'b0;
    // OP allows bit 30 only on ADD/SUB and SRL/SRA; OP-IMM carries imm bits there except SLLI.
    illegal = io.in_funct7_5 &
              (io.in_is_imm ? (io.in_funct3 == 3'b001)
                            : (io.in_funct3 != 3'b000 && io.in_funct3 != 3'b101));
    case (io.in_funct3)
      3'b000:  alu_op = (!io.in_is_imm && io.in_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  use_cmp = 1'b1;
      3'b011:  use_cmp = 1'b1;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = io.in_funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase

    case (alu_op)
      ALU_SUB: alu_res = io.in_rs1 - op_b;
      ALU_SLL: alu_res = io.in_rs1 << shamt;
      ALU_SRL: alu_res = io.in_rs1 >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(io.in_rs1) >>> shamt);
      ALU_XOR: alu_res = io.in_rs1 ^ op_b;
      ALU_OR:  alu_res = io.in_rs1 | op_b;
      ALU_AND: alu_res = io.in_rs1 & op_b;
      default: alu_res = io.in_rs1 + op_b;
    endcase

    // funct3[0] distinguishes SLTU (011) from SLT (010)
    lt = io.in_funct3[0] ? (io.in_rs1 < op_b) : ($signed(io.in_rs1) < $signed(op_b));

    new_entry.illegal = illegal;
    new_entry.tag     = io.in_tag;
    new_entry.wen     = (io.in_tag != '0) && !illegal;
    if (illegal)      new_entry.result = 32'd0;
    else if (use_cmp) new_entry.result = {31'd0, lt};
    else              new_entry.result = alu_res;
  end

  assign load_main   = !out_valid_q || io.out_ready;
  // Skid mode: ready comes straight from a flop so upstream timing is decoupled.
  assign io.in_ready = SKID_EN ? !skid_full_q : load_main;
  assign accept      = io.in_valid && io.in_ready;

  always_comb begin
    main_d      = main_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (load_main) begin
      if (skid_full_q) begin
        // Oldest entry first; a same-cycle accept refills the freed skid.
        main_d      = skid_q;
        out_valid_d = 1'b1;
        if (accept) skid_d = new_entry;
        else        skid_full_d = 1'b0;
      end else if (accept) begin
        main_d      = new_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept && SKID_EN) begin
      skid_d      = new_entry;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
    end
  end

  assign io.out_valid   = out_valid_q;
  assign io.out_result  = main_q.result;
  assign io.out_tag     = main_q.tag;
  assign io.out_wen     = main_q.wen;
  assign io.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_riscv_exec_stage.sv
// tb/tb_riscv_exec_stage.sv - directed vector bench for riscv_exec_stage
module tb_riscv_exec_stage;

  logic clk;
  logic rst_n;
  logic flush;

  riscv_exec_stage_if #(.TAG_W(5)) bus ();

  riscv_exec_stage #(.TAG_W(5), .SKID_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        is_imm;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  tag;
    logic [31:0] exp_res;
    logic        exp_wen;
    logic        exp_ill;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic is_imm, input logic [2:0] f3, input logic f7,
                     input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                     input logic [4:0] tag, input logic [31:0] er, input logic ew, input logic ei);
    vec_t v;
    v.name = name; v.is_imm = is_imm; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.tag = tag; v.exp_res = er; v.exp_wen = ew; v.exp_ill = ei;
    vq.push_back(v);
  endtask

  task automatic drive(input logic is_imm, input logic [2:0] f3, input logic f7,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [4:0] tag);
    bus.in_valid    = 1'b1;
    bus.in_is_imm   = is_imm;
    bus.in_funct3   = f3;
    bus.in_funct7_5 = f7;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_imm      = imm;
    bus.in_tag      = tag;
  endtask

  task automatic fill_ab();
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 5'd1);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, 32'd10, 32'd20, 32'd0, 5'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // name imm f3 f7 rs1 rs2 imm tag exp_res wen ill
    add("sub_t1",   0, 3'b000, 1, 32'd5,        32'd7,        32'd0,        5'd3, 32'hFFFFFFFE, 1, 0);
    add("add",      0, 3'b000, 0, 32'd5,        32'd7,        32'd0,        5'd1, 32'd12,       1, 0);
    add("addi_f7",  1, 3'b000, 1, 32'd10,       32'd0,        32'hFFFFFFFF, 5'd4, 32'd9,        1, 0);
    add("srai",     1, 3'b101, 1, 32'h80000000, 32'd0,        32'h00000404, 5'd5, 32'hF8000000, 1, 0);
    add("srli",     1, 3'b101, 0, 32'h80000000, 32'd0,        32'd4,        5'd5, 32'h08000000, 1, 0);
    add("slt",      0, 3'b010, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd6, 32'd1,        1, 0);
    add("sltu",     0, 3'b011, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd6, 32'd0,        1, 0);
    add("slt_tag0", 0, 3'b010, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd0, 32'd1,        0, 0);
    add("xor",      0, 3'b100, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        5'd7, 32'h0FF00FF0, 1, 0);
    add("or",       0, 3'b110, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        5'd8, 32'hFFF0FFF0, 1, 0);
    add("and",      0, 3'b111, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        5'd9, 32'hF000F000, 1, 0);
    add("sll_b_hi", 0, 3'b001, 0, 32'd1,        32'h00000025, 32'd0,        5'd10, 32'h00000020, 1, 0);
    add("ill_xor",  0, 3'b100, 1, 32'd3,        32'd5,        32'd0,        5'd5, 32'd0,        0, 1);
    add("ill_slli", 1, 3'b001, 1, 32'd3,        32'd0,        32'd1,        5'd5, 32'd0,        0, 1);
    add("sra",      0, 3'b101, 1, 32'h80000000, 32'd31,       32'd0,        5'd11, 32'hFFFFFFFF, 1, 0);
    add("andi_f7",  1, 3'b111, 1, 32'hFFFF0000, 32'd0,        32'hFFFFF0FF, 5'd2, 32'hFFFF0000, 1, 0);
    add("sub_neg",  0, 3'b000, 1, 32'd0,        32'd1,        32'd0,        5'd12, 32'hFFFFFFFF, 1, 0);
    add("sltu_lt",  0, 3'b011, 0, 32'd1,        32'hFFFFFFFF, 32'd0,        5'd13, 32'd1,        1, 0);
    add("slt_min",  0, 3'b010, 0, 32'h80000000, 32'h7FFFFFFF, 32'd0,        5'd14, 32'd1,        1, 0);

    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    bus.in_valid = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_tag", {27'd0, bus.out_tag}, 32'd0);
    chk("rst_out_wen", {31'd0, bus.out_wen}, 32'd0);
    chk("rst_out_illegal", {31'd0, bus.out_illegal}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rel_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Vector table: one instruction per pass, result checked one cycle after accept
    foreach (vq[i]) begin
      drive(vq[i].is_imm, vq[i].f3, vq[i].f7, vq[i].rs1, vq[i].rs2, vq[i].imm, vq[i].tag);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({vq[i].name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({vq[i].name, "_result"}, bus.out_result, vq[i].exp_res);
      chk({vq[i].name, "_tag"}, {27'd0, bus.out_tag}, {27'd0, vq[i].tag});
      chk({vq[i].name, "_wen"}, {31'd0, bus.out_wen}, {31'd0, vq[i].exp_wen});
      chk({vq[i].name, "_illegal"}, {31'd0, bus.out_illegal}, {31'd0, vq[i].exp_ill});
      @(negedge clk);
    end
    chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // T4: stall with A, B, C back to back; release and expect A, B, C in order
    bus.out_ready = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 5'd1);
    @(negedge clk);
    chk("t4_a_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t4_a_result", bus.out_result, 32'd3);
    drive(1'b0, 3'b000, 1'b0, 32'd10, 32'd20, 32'd0, 5'd2);
    @(negedge clk);
    chk("t4_skid_in_ready", {31'd0, bus.in_ready}, 32'd0);
    drive(1'b0, 3'b100, 1'b0, 32'h000000FF, 32'h0000000F, 32'd0, 5'd3);
    for (int k = 0; k < 4; k++) begin
      chk("t4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t4_hold_result", bus.out_result, 32'd3);
      chk("t4_hold_tag", {27'd0, bus.out_tag}, 32'd1);
      chk("t4_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    chk("t4_hold_result_last", bus.out_result, 32'd3);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_b_result", bus.out_result, 32'd30);
    chk("t4_b_tag", {27'd0, bus.out_tag}, 32'd2);
    chk("t4_b_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t4_c_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t4_c_result", bus.out_result, 32'h000000F0);
    chk("t4_c_tag", {27'd0, bus.out_tag}, 32'd3);
    @(negedge clk);
    chk("t4_drained", {31'd0, bus.out_valid}, 32'd0);

    // T6a: flush with full skid and a new input offered
    fill_ab();
    chk("t6_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b0, 3'b110, 1'b0, 32'd4, 32'd8, 32'd0, 5'd4);
    bus.out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("t6_flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    chk("t6_flush_no_resurrect", {31'd0, bus.out_valid}, 32'd0);

    // T6b: asynchronous reset in the middle of a stall
    fill_ab();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_rst_out_result", bus.out_result, 32'd0);
    chk("t6_rst_out_tag", {27'd0, bus.out_tag}, 32'd0);
    chk("t6_rst_out_wen", {31'd0, bus.out_wen}, 32'd0);
    chk("t6_rst_out_illegal", {31'd0, bus.out_illegal}, 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("t6_post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    drive(1'b0, 3'b000, 1'b0, 32'd100, 32'd23, 32'd0, 5'd9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t6_post_rst_result", bus.out_result, 32'd123);
    chk("t6_post_rst_tag", {27'd0, bus.out_tag}, 32'd9);
    @(negedge clk);
    chk("t6_post_rst_single", {31'd0, bus.out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
